imem_loader: RTL and testbench
==============================

# imem_loader

Write-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It drives a word-write port into the instruction RAM at consecutive word addresses from 0, and holds the CPU in stall until a complete program has been written. It sits between the boot/debug byte source (UART receiver) and the instruction RAM write port.

## Interface
- `DEPTH`, 64: number of 32-bit words in the instruction RAM; maximum program length.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `start`  in  1  one-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR).
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `we`  out  1  one-cycle word-write strobe to instruction RAM.
- `wr_addr`  out  32  byte address of the word being written; always word-aligned (`[1:0]`=0).
- `wr_data`  out  32  word being written.
- `cpu_hold`  out  1  stall/reset request to the CPU while loading or after an error.
- `done`  out  1  load completed successfully; level, held until next `start` or `reset`.
- `error`  out  1  load aborted; level, held until next `start` or `reset`.

## Operation
- Byte transfer occurs on a cycle with `byte_valid && byte_ready`; no other cycle consumes a byte.
- Stream format: `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then 4·N payload bytes, least-significant byte of each word first.
- States:
  - IDLE: `byte_ready`=0. `start` moves to LEN0.
  - LEN0: capture `LEN_LO`, then move to LEN1.
  - LEN1: capture `LEN_HI`. If N==0 or N>DEPTH, move to ERR; otherwise clear the word index and byte index, then move to DATA.
  - DATA: shift each byte into `wr_data[8k+7:8k]`, where k is the byte index 0..3. On the 4th byte:
    - register `we`=1 and `wr_addr`=word_index<<2;
    - increment word_index;
    - if word_index was N−1, move to CSUM (macro defined) or DONE.
  - CSUM: present only with the macro; see Configuration.
  - DONE: `done`=1, `cpu_hold`=0, `byte_ready`=0.
  - ERR: `error`=1, `cpu_hold`=1, `byte_ready`=0.
- `byte_ready`=1 in LEN0, LEN1, DATA, CSUM.
- `cpu_hold`=1 in LEN0, LEN1, DATA, CSUM, ERR; 0 in IDLE and DONE.
- `start` from DONE or ERR:
  - clears `done`/`error`;
  - enters LEN0 on the next edge.
- `start` in LEN0..CSUM is ignored; the load in progress continues.
- Word index width is clog2(DEPTH)+1. `wr_addr` upper bits are zero.
- Bytes offered while `byte_ready`=0 are not consumed and are not counted.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `we`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `error`=0.
- `start` sampled at edge t gives `byte_ready`=1 and `cpu_hold`=1 from cycle t+1.
- Write latency: the 4th byte of a word is accepted at edge t. `we`=1 with valid `wr_addr`/`wr_data` during cycle t+1, for exactly one cycle.
- `byte_ready` remains 1 during a `we` cycle. A byte accepted in that cycle goes into the next word and does not disturb `wr_data` until the following edge.
- Last word: `we` pulse and the `done` rise occur in the same cycle t+1. Without the macro, `cpu_hold` falls in that same cycle.
- Back-to-back: at full source rate, a program of N words takes 2+4N accepted-byte cycles (+1 with the macro).
- `reset` mid-load: everything returns to reset values on the next edge. Words already written stay in RAM. No further `we` is issued, including a pending one.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - a running XOR of all payload bytes is kept;
  - after the last word, state CSUM accepts one byte;
  - if it equals the XOR, move to DONE; otherwise move to ERR;
  - the last word's `we` still occurs before the check;
  - `done` rises one accepted byte later than without the macro.
- Not defined: no CSUM state and no XOR register. DATA goes directly to DONE.

## Test plan
- Reset then idle: all outputs 0; `byte_valid`=1 with 0xAA for 5 cycles → `byte_ready`=0, no `we`.
- Load N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE at full rate → two `we` pulses: (0x0, 0x12345678) then (0x4, 0xDEADBEEF); `done`=1, `cpu_hold`=0 afterward.
- Same load with `byte_valid` toggled every other cycle → identical writes; `we` exactly one cycle each; `cpu_hold`=1 throughout the load.
- N=0 and N=65 (DEPTH=64) → ERR after LEN_HI, `error`=1, `cpu_hold`=1, no `we`; then `start` → LEN0, `error`=0.
- `reset` after 6 payload bytes of an N=4 load → exactly one `we` seen (addr 0x0); all outputs at reset values next cycle.
- With `IMEM_LOADER_CHECKSUM_EN`, N=1 payload 01 02 03 04:
  - checksum 0x04 → `done`=1;
  - checksum 0x05 → `error`=1, `cpu_hold`=1;
  - both cases write 0x04030201 to 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-RAM word loader.
// Accepts a length-prefixed byte stream (LEN_LO, LEN_HI, then 4*N payload
// bytes, little-endian), packs the payload into 32-bit words and issues
// one-cycle word writes at consecutive addresses from 0. Holds the CPU in
// stall while a load is in progress or after an aborted load.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a one-byte
// XOR checksum after the payload; a mismatch aborts the load.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH) + 1;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [7:0]         len_lo_reg;
  logic [IDX_W-1:0]   last_idx_reg;
  logic [IDX_W-1:0]   word_idx_reg;
  logic [1:0]         byte_idx_reg;
  logic               we_reg;
  logic [31:0]        wr_addr_reg;
  logic [31:0]        wr_data_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         xor_reg;
`endif

  logic               accept;
  logic               data_accept;
  logic               word_done;
  logic               last_word;
  logic [15:0]        len_full;
  logic               len_bad;
  logic [3:0]         lane_hit;

  // Handshake acceptance and word-boundary decode.
  assign accept      = byte_valid && byte_ready;
  assign data_accept = accept && (state_reg == S_DATA);
  assign word_done   = data_accept && (byte_idx_reg == 2'd3);
  assign last_word   = word_done && (word_idx_reg == last_idx_reg);
  assign len_full    = {byte_data, len_lo_reg};
  assign len_bad     = (len_full == 16'd0) || (len_full > DEPTH_W);

  // One write-enable per byte lane of the word being assembled.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = data_accept && (byte_idx_reg == 2'(gi));
    end
  endgenerate

  assign we      = we_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

  // Byte_ready depends on state only, so acceptance never loops through it.
  always_comb begin
    byte_ready = 1'b0;
    case (state_reg)
      S_LEN0, S_LEN1, S_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 byte_ready = 1'b1;
`endif
      default:                byte_ready = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state_reg;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LEN0;
      end
      S_LEN0: begin
        cpu_hold = 1'b1;
        if (accept) state_next = S_LEN1;
      end
      S_LEN1: begin
        cpu_hold = 1'b1;
        if (accept) state_next = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        cpu_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_word) state_next = S_CSUM;
`else
        if (last_word) state_next = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        cpu_hold = 1'b1;
        if (accept) state_next = (byte_data == xor_reg) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN0;
      end
      S_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_next = S_LEN0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word packing, write strobe generation.
  // Reset drops any write strobe that would otherwise appear next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_reg   <= '0;
      last_idx_reg <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      we_reg       <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_reg      <= '0;
`endif
    end else begin
      we_reg <= 1'b0;
      if (accept && (state_reg == S_LEN0)) begin
        len_lo_reg <= byte_data;
      end
      if (accept && (state_reg == S_LEN1)) begin
        last_idx_reg <= IDX_W'(len_full - 16'd1);
        word_idx_reg <= '0;
        byte_idx_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_reg      <= '0;
`endif
      end
      for (int i = 0; i < 4; i++) begin
        if (lane_hit[i]) wr_data_reg[8*i +: 8] <= byte_data;
      end
      if (data_accept) begin
        byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_reg      <= xor_reg ^ byte_data;
`endif
      end
      if (word_done) begin
        we_reg       <= 1'b1;
        wr_addr_reg  <= {{(30-IDX_W){1'b0}}, word_idx_reg, 2'b00};
        word_idx_reg <= word_idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked against a
// behavioural model of the stream format (length rules, word packing,
// optional XOR checksum). Follows IMEM_LOADER_CHECKSUM_EN like the design.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  // Write capture, sampled away from the active edge.
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic        cap_done[$];
  int          we_double = 0;
  logic        we_prev   = 1'b0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_done.push_back(done);
      $display("write addr=0x%08h data=0x%08h done=%0b", wr_addr, wr_data, done);
    end
    if (we === 1'b1 && we_prev === 1'b1) we_double++;
    we_prev = we;
  end

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_done.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers the stream; mode 0 = full rate, 1 = every other cycle, 2 = random.
  task automatic send(input logic [7:0] s[$], input int mode, input bit noise, output int hold_bad);
    int  i   = 0;
    int  cyc = 0;
    bit  tog = 1'b0;
    bit  acc;
    hold_bad = 0;
    while (i < s.size() && cyc < 3000) begin
      @(negedge clk);
      if (cpu_hold !== 1'b1) hold_bad = 1;
      byte_data = s[i];
      case (mode)
        0:       byte_valid = 1'b1;
        1:       begin byte_valid = tog; tog = ~tog; end
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      start = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      acc = byte_valid && (byte_ready === 1'b1);
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    chk("stream_budget", 32'(i == s.size()), 32'd1);
  endtask

  // Builds the stream for N words, runs it, and checks against the model.
  // csum_mask = 0 sends the correct checksum, otherwise it is XORed in.
  task automatic run_load(input string tag, input int n, input logic [7:0] pay[$],
                          input logic [7:0] csum_mask, input int mode, input bit noise);
    logic [7:0]  s[$];
    logic [7:0]  x;
    logic [31:0] w;
    int          hold_bad;
    bit          len_ok;
    bit          exp_ok;
    int          exp_wr;
    s = {};
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    len_ok = (n >= 1) && (n <= DEPTH);
    exp_ok = len_ok;
    if (len_ok) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        s.push_back(pay[i]);
        x = x ^ pay[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(x ^ csum_mask);
      exp_ok = (csum_mask == 8'h00);
`endif
    end
    exp_wr = len_ok ? n : 0;
    $display("load %s n=%0d mode=%0d bytes=%0d", tag, n, mode, s.size());
    clear_cap();
    pulse_start();
    send(s, mode, noise, hold_bad);
    repeat (2) @(negedge clk);
    chk($sformatf("%s_nwr", tag), 32'(cap_addr.size()), 32'(exp_wr));
    for (int i = 0; i < exp_wr && i < cap_addr.size(); i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = w | (32'(pay[4*i+k]) << (8*k));
      chk($sformatf("%s_addr%0d", tag, i), cap_addr[i], 32'(i * 4));
      chk($sformatf("%s_data%0d", tag, i), cap_data[i], w);
    end
    if (exp_wr > 0 && cap_done.size() == exp_wr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk($sformatf("%s_done_at_last_we", tag), 32'(cap_done[exp_wr-1]), 32'd0);
`else
      chk($sformatf("%s_done_at_last_we", tag), 32'(cap_done[exp_wr-1]), 32'd1);
`endif
    end
    chk($sformatf("%s_done", tag), 32'(done), 32'(exp_ok));
    chk($sformatf("%s_error", tag), 32'(error), 32'(!exp_ok));
    chk($sformatf("%s_hold", tag), 32'(cpu_hold), 32'(!exp_ok));
    chk($sformatf("%s_ready", tag), 32'(byte_ready), 32'd0);
    chk($sformatf("%s_hold_in_load", tag), 32'(hold_bad), 32'd0);
    chk($sformatf("%s_we_single", tag), 32'(we_double), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s_ready", tag), 32'(byte_ready), 32'd0);
    chk($sformatf("%s_we", tag), 32'(we), 32'd0);
    chk($sformatf("%s_addr", tag), wr_addr, 32'd0);
    chk($sformatf("%s_data", tag), wr_data, 32'd0);
    chk($sformatf("%s_hold", tag), 32'(cpu_hold), 32'd0);
    chk($sformatf("%s_done", tag), 32'(done), 32'd0);
    chk($sformatf("%s_error", tag), 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    logic [7:0] s[$];
    int         hold_bad;
    int         n;

    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Idle: offered bytes are never taken.
    clear_cap();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      chk("idle_ready", 32'(byte_ready), 32'd0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_we", 32'(cap_addr.size()), 32'd0);
    check_reset_outputs("idle");

    // Directed two-word load at full rate, then with a toggling source.
    pay = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("n2_full", 2, pay, 8'h00, 0, 1'b0);
    run_load("n2_toggle", 2, pay, 8'h00, 1, 1'b0);

    // Illegal lengths abort after LEN_HI.
    pay = {};
    run_load("n0", 0, pay, 8'h00, 0, 1'b0);
    run_load("n65", DEPTH + 1, pay, 8'h00, 0, 1'b0);
    // Restart out of ERR: ready and hold one cycle after start, error cleared.
    pulse_start();
    chk("restart_ready", 32'(byte_ready), 32'd1);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    chk("restart_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset part-way through a four-word load.
    clear_cap();
    s = {8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start();
    send(s, 0, 1'b0, hold_bad);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    chk("midrst_nwr", 32'(cap_addr.size()), 32'd1);
    if (cap_addr.size() >= 1) begin
      chk("midrst_addr", cap_addr[0], 32'h0);
      chk("midrst_data", cap_data[0], 32'h44332211);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load("cs_good", 1, pay, 8'h00, 0, 1'b0);
    run_load("cs_bad", 1, pay, 8'h01, 0, 1'b0);
`endif

    // Randomized loads: lengths, source rate, stray start pulses, checksums.
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(0, 300));
        2:       n = DEPTH;
        default: n = int'($urandom_range(1, 6));
      endcase
      pay = {};
      if (n >= 1 && n <= DEPTH)
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_load($sformatf("rnd%0d", t), n, pay,
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
